// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared types for the execute-stage MDU issue controller: ALU opcodes, FSM states
// and opcode class helpers.
package mdu_issue_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE, MDU_EXEC, MDU_DONE, MDU_DRAIN
  } mdu_state_e;

  function automatic logic is_mext_op(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_result_cache.sv
// One-entry result cache for M-extension ops; built only when MDU_RESULT_CACHE_EN is defined.
`ifdef MDU_RESULT_CACHE_EN
module mdu_result_cache
  import mdu_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inval,
  input  logic [XLEN-1:0] lk_a,
  input  logic [XLEN-1:0] lk_b,
  input  alu_op_e         lk_op,
  output logic            lk_hit_c,
  output logic [XLEN-1:0] lk_result_c,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_a,
  input  logic [XLEN-1:0] fill_b,
  input  alu_op_e         fill_op,
  input  logic [XLEN-1:0] fill_result
);

  logic            valid_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  alu_op_e         op_q;

  // Invalidate wins over a same-cycle fill
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      result_q <= '0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      valid_q  <= 1'b1;
      a_q      <= fill_a;
      b_q      <= fill_b;
      op_q     <= fill_op;
      result_q <= fill_result;
    end
  end

  assign lk_hit_c    = valid_q && (lk_a == a_q) && (lk_b == b_q) && (lk_op == op_q);
  assign lk_result_c = result_q;

endmodule
`endif

// File: rtl/mdu_issue_ctrl.sv
// Execute-stage issue controller for the shared multi-cycle ALU/divider.
// Optional one-entry M-ext result cache enabled by defining MDU_RESULT_CACHE_EN.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  alu_op_e          req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  input  logic             flush,
  output logic             busy,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output alu_op_e          alu_op,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_ready
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mdu_state_e       state, state_nx;
  logic [CNT_W-1:0] cyc_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             hit_pend;
  logic             accept, done_ok, timeout, hit;
  logic [XLEN-1:0]  hit_result;

  logic             rsp_valid_d, rsp_err_d, busy_d;
  logic [XLEN-1:0]  rsp_result_d, alu_a_d, alu_b_d;
  logic [TAG_W-1:0] rsp_tag_d;
  alu_op_e          alu_op_d;

  // A pending cache hit blocks new requests for its one IDLE cycle
  assign req_ready = (state == MDU_IDLE) && !flush && !hit_pend;
  assign accept    = req_valid && req_ready;
  // The first EXEC cycle's ready may still reflect the previous divide, so it is ignored
  assign done_ok   = (state == MDU_EXEC) && !flush && alu_ready && (cyc_cnt != '0);
  assign timeout   = (state == MDU_EXEC) && !flush && !done_ok && (cyc_cnt == CNT_LAST);

`ifdef MDU_RESULT_CACHE_EN
  logic cache_hit_c;

  mdu_result_cache u_cache (
    .clk        (clk),
    .reset      (reset),
    .inval      (timeout),
    .lk_a       (req_a),
    .lk_b       (req_b),
    .lk_op      (req_op),
    .lk_hit_c   (cache_hit_c),
    .lk_result_c(hit_result),
    .fill_en    (done_ok && is_mext_op(alu_op)),
    .fill_a     (alu_a),
    .fill_b     (alu_b),
    .fill_op    (alu_op),
    .fill_result(alu_result)
  );

  assign hit = accept && is_mext_op(req_op) && cache_hit_c;
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MDU_IDLE;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= ALU_ADD;
    end else begin
      state      <= state_nx;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_result <= rsp_result_d;
      rsp_tag    <= rsp_tag_d;
      busy       <= busy_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op     <= alu_op_d;
    end
  end

  // Next state; flush takes priority everywhere
  always_comb begin
    state_nx = state;
    unique case (state)
      MDU_IDLE: begin
        if (hit_pend && !flush)  state_nx = MDU_DONE;
        else if (accept && !hit) state_nx = MDU_EXEC;
      end
      MDU_EXEC: begin
        if (flush)                   state_nx = MDU_DRAIN;
        else if (done_ok)            state_nx = MDU_DONE;
        else if (timeout)            state_nx = MDU_DRAIN;
      end
      MDU_DONE: begin
        if (flush || rsp_ready)      state_nx = MDU_IDLE;
      end
      MDU_DRAIN: begin
        if (alu_ready)               state_nx = (rsp_err && !flush) ? MDU_DONE : MDU_IDLE;
      end
      default:                       state_nx = MDU_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    rsp_valid_d  = (state_nx == MDU_DONE);
    busy_d       = (state_nx != MDU_IDLE);
    rsp_result_d = rsp_result;
    rsp_tag_d    = rsp_tag;
    rsp_err_d    = rsp_err;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_op_d     = ALU_ADD;
    if (accept) begin
      alu_a_d   = req_a;
      alu_b_d   = req_b;
      rsp_err_d = 1'b0;
    end
    if (state_nx == MDU_EXEC) alu_op_d = accept ? req_op : alu_op;
    if (hit) begin
      rsp_result_d = hit_result;
      rsp_tag_d    = req_tag;
    end
    if (done_ok) begin
      rsp_result_d = alu_result;
      rsp_tag_d    = tag_q;
      rsp_err_d    = 1'b0;
    end
    if (timeout) begin
      rsp_result_d = '0;
      rsp_tag_d    = tag_q;
      rsp_err_d    = 1'b1;
    end
    if (flush) rsp_err_d = 1'b0;
  end

  // Tag latch, saturating EXEC cycle counter, cache-hit pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt  <= '0;
      tag_q    <= '0;
      hit_pend <= 1'b0;
    end else begin
      hit_pend <= hit;
      if (accept) begin
        cyc_cnt <= '0;
        tag_q   <= req_tag;
      end else if ((state == MDU_EXEC) && (cyc_cnt != CNT_LAST)) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
    end
  end

endmodule
